// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width / address width
//   REG_ZERO                : address of the hardwired zero register
//   port_field()            : extracts field k of width w from a flattened bus
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // Callers zero-extend their flattened bus to RP_BUS_MAX bits and
    // truncate the returned FIELD_MAX-bit value to the field width they need.
    localparam int RP_BUS_MAX = 256;
    localparam int FIELD_MAX  = 64;

    function automatic logic [FIELD_MAX-1:0] port_field(
        input logic [RP_BUS_MAX-1:0] bus,
        input int                    k,
        input int                    w
    );
        logic [RP_BUS_MAX-1:0] shifted;
        shifted = bus >> (k * w);
        return shifted[FIELD_MAX-1:0] & ((FIELD_MAX'(1) << w) - FIELD_MAX'(1));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy tracking for RAW/WAW hazard detection.
//   clk, reset_n        : clock, synchronous active-low reset
//   we, wa              : writeback write; releases busy[wa] if it was set
//   rsv_req, rsv_addr   : issue-stage reservation request
//   rsv_ok              : combinational accept (refuses reg 0 and busy regs)
//   busy                : current busy bit-vector (registered)
//   busy_cnt            : registered number of busy registers
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic                    rsv_req,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    rsv_ok,
    output logic [(1<<ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [ADDR_W:0]  cnt_reg;
    logic [ADDR_W:0]  cnt_next;
    logic             wr_clear;

    // Decision uses pre-edge busy, so a write and a reservation to the same
    // register never both take effect: busy=1 -> write releases, reservation
    // refused; busy=0 -> reservation wins and the bit ends set.
    assign rsv_ok   = rsv_req && (rsv_addr != ZERO_A) && !busy_reg[rsv_addr];
    assign wr_clear = we && (wa != ZERO_A) && busy_reg[wa];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            assign busy_next[gi] =
                (busy_reg[gi] && !(wr_clear && (wa == ADDR_W'(gi)))) ||
                (rsv_ok && (rsv_addr == ADDR_W'(gi)));
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        if (rsv_ok && !wr_clear)
            cnt_next = cnt_reg + CNT_ONE;
        else if (!rsv_ok && wr_clear)
            cnt_next = cnt_reg - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign busy     = busy_reg;
    assign busy_cnt = cnt_reg;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-read-port register file with hardwired zero register and
// busy scoreboard. Optional write-to-read bypass via macro REGFILE_BYPASS_EN.
//   clk, reset_n  : clock, synchronous active-low reset
//   we, wa, wd    : write port (writeback stage)
//   ra / rd       : NUM_RD flattened read addresses / combinational read data
//   rd_busy       : busy flag of the register each read port addresses
//   rsv_req, rsv_addr, rsv_ok : destination reservation handshake
//   busy_cnt      : registered count of busy registers
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_req,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]     mem_reg [DEPTH];
    logic [DEPTH-1:0]      busy_vec;
    logic [RP_BUS_MAX-1:0] ra_ext;

    assign ra_ext = RP_BUS_MAX'(ra);

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .wa       (wa),
        .rsv_req  (rsv_req),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .busy     (busy_vec),
        .busy_cnt (busy_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (we && (wa != ZERO_A)) begin
            mem_reg[wa] <= wd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [FIELD_MAX-1:0] ra_field;
            logic [ADDR_W-1:0]    ra_k;
            logic [DATA_W-1:0]    stored;

            assign ra_field = port_field(ra_ext, gi, ADDR_W);
            assign ra_k     = ra_field[ADDR_W-1:0];
            // Register 0 is forced to zero regardless of array contents.
            assign stored   = (ra_k == ZERO_A) ? '0 : mem_reg[ra_k];

`ifdef REGFILE_BYPASS_EN
            logic byp_hit;
            assign byp_hit = we && (wa != ZERO_A) && (ra_k == wa);
            assign rd[gi*DATA_W +: DATA_W] = byp_hit ? wd : stored;
            // The in-flight write releases the register unless a new producer
            // is accepted for it in this same cycle.
            assign rd_busy[gi] = byp_hit ? (rsv_ok && (rsv_addr == wa))
                                         : busy_vec[ra_k];
`else
            assign rd[gi*DATA_W +: DATA_W] = stored;
            assign rd_busy[gi] = busy_vec[ra_k];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed test of regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2). The driver
// pushes the expected outputs for each cycle into a queue; a monitor on the
// falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [4:0] M_RD0 = 5'b00001;
    localparam logic [4:0] M_RD1 = 5'b00010;
    localparam logic [4:0] M_RDB = 5'b00100;
    localparam logic [4:0] M_OK  = 5'b01000;
    localparam logic [4:0] M_CNT = 5'b10000;

    typedef struct {
        string       tag;
        logic [4:0]  mask;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rdb;
        logic        ok;
        logic [5:0]  cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rd_busy;
    logic              rsv_req;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_ok;
    logic [AW:0]       busy_cnt;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .rsv_req  (rsv_req),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .busy_cnt (busy_cnt)
    );

    task automatic cmp(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", tag, name, act, req);
        end else begin
            $display("ok   %s.%s = %h", tag, name, act);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mask & M_RD0) cmp(e.tag, "rd0",     rd[31:0],          e.rd0);
            if (e.mask & M_RD1) cmp(e.tag, "rd1",     rd[63:32],         e.rd1);
            if (e.mask & M_RDB) cmp(e.tag, "rd_busy", 32'(rd_busy),      32'(e.rdb));
            if (e.mask & M_OK)  cmp(e.tag, "rsv_ok",  32'(rsv_ok),       32'(e.ok));
            if (e.mask & M_CNT) cmp(e.tag, "busy_cnt",32'(busy_cnt),     32'(e.cnt));
        end
    end

    // One cycle of stimulus: inputs applied just after the rising edge,
    // expectation queued for the monitor.
    task automatic step(input string tag,
                        input logic rn, input logic w_en, input logic [4:0] w_a,
                        input logic [31:0] w_d, input logic [4:0] r0, input logic [4:0] r1,
                        input logic rq, input logic [4:0] rq_a,
                        input logic [4:0] mask, input logic [31:0] e_rd0,
                        input logic [31:0] e_rd1, input logic [1:0] e_rdb,
                        input logic e_ok, input logic [5:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n  = rn;
        we       = w_en;
        wa       = w_a;
        wd       = w_d;
        ra       = {r1, r0};
        rsv_req  = rq;
        rsv_addr = rq_a;
        e.tag  = tag;
        e.mask = mask;
        e.rd0  = e_rd0;
        e.rd1  = e_rd1;
        e.rdb  = e_rdb;
        e.ok   = e_ok;
        e.cnt  = e_cnt;
        if (mask != 5'b0) exp_q.push_back(e);
    endtask

    localparam logic [4:0] M_ALL = M_RD0 | M_RD1 | M_RDB | M_OK | M_CNT;

    initial begin
        reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
        rsv_req = 1'b0; rsv_addr = '0;

        //    tag        rn we wa  wd            r0  r1  rq ra  mask  rd0 rd1 rdb ok cnt
        step("rst_a",    0, 0, 0,  0,            7,  31, 0, 0,  5'b0, 0, 0, 0, 0, 0);
        step("rst_b",    0, 0, 0,  0,            7,  31, 0, 0,  M_ALL, 0, 0, 0, 0, 0);
        step("wr3",      1, 1, 3,  32'hDEADBEEF, 3,  0,  0, 0,  M_RD0|M_RD1|M_RDB,
             BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0);
        step("wr0",      1, 1, 0,  32'h1,        3,  0,  0, 0,  M_RD0|M_RD1|M_RDB,
             32'hDEADBEEF, 0, 0, 0, 0);
        step("rsv5",     1, 0, 0,  0,            5,  0,  1, 5,  M_RD1|M_RDB|M_OK|M_CNT,
             0, 0, 0, 1, 0);
        step("rsv5_again",1,0, 0,  0,            3,  5,  1, 5,  M_RD0|M_RDB|M_OK|M_CNT,
             32'hDEADBEEF, 0, 2'b10, 0, 1);
        step("wr5",      1, 1, 5,  32'h55,       3,  5,  0, 0,  M_RD0|M_RDB|M_CNT,
             32'hDEADBEEF, 0, BYP ? 2'b00 : 2'b10, 0, 1);
        step("after_wr5",1, 0, 0,  0,            3,  5,  0, 0,  M_RD1|M_RDB|M_CNT,
             0, 32'h55, 0, 0, 0);
        step("wr_rsv9_a",1, 1, 9,  32'h99,       9,  0,  1, 9,  M_RD0|M_RDB|M_OK|M_CNT,
             BYP ? 32'h99 : 32'h0, 0, BYP ? 2'b01 : 2'b00, 1, 0);
        step("wr_rsv9_b",1, 1, 9,  32'h9A,       9,  0,  1, 9,  M_RD0|M_RDB|M_OK|M_CNT,
             BYP ? 32'h9A : 32'h99, 0, BYP ? 2'b00 : 2'b01, 0, 1);
        step("after9",   1, 0, 0,  0,            9,  0,  0, 0,  M_RD0|M_RDB|M_CNT,
             32'h9A, 0, 0, 0, 0);
        step("byp12",    1, 1, 12, 32'hA5A5A5A5, 12, 0,  0, 0,  M_RD0|M_RDB,
             BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0, 0, 0);
        step("after12",  1, 0, 0,  0,            12, 0,  0, 0,  M_RD0,
             32'hA5A5A5A5, 0, 0, 0, 0);
        step("rsv1",     1, 0, 0,  0,            0,  0,  1, 1,  M_OK|M_CNT, 0, 0, 0, 1, 0);
        step("rsv2_wr1", 1, 1, 1,  32'h11,       0,  0,  1, 2,  M_OK|M_CNT, 0, 0, 0, 1, 1);
        step("rsv4",     1, 0, 0,  0,            1,  2,  1, 4,  M_ALL,
             32'h11, 0, 2'b10, 1, 1);
        step("wr2",      1, 1, 2,  32'h22,       4,  2,  0, 0,  M_RD1|M_RDB|M_CNT,
             0, BYP ? 32'h22 : 32'h0, BYP ? 2'b01 : 2'b11, 0, 2);
        step("rst_mid",  0, 1, 4,  32'h44,       2,  4,  1, 6,  M_RD0|M_CNT,
             32'h22, 0, 0, 0, 1);
        step("post_rst", 1, 0, 0,  0,            4,  2,  0, 0,  M_ALL, 0, 0, 0, 0, 0);
        step("post_rst2",1, 0, 0,  0,            1,  6,  0, 0,  M_ALL, 0, 0, 0, 0, 0);
        step("idle",     1, 0, 0,  0,            0,  0,  0, 0,  5'b0, 0, 0, 0, 0, 0);

        // Bounded drain of the scoreboard queue.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
